// File: rtl/bin_to_gray_counter.sv
// Binary up/down counter with parallel load and a registered Gray-code output.
// A sticky flag records any count step that moves the Gray code by other than one bit.
module bin_to_gray_counter #(
   parameter int WIDTH     = 3,
   parameter int RESET_VAL = 0
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             load_in,
   input  logic [WIDTH-1:0] bin_in,
   input  logic             en_in,
   input  logic             up_in,
   input  logic             clr_err_in,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             wrap_out,
   output logic             step_err_out
);

   localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic is_single_bit(input logic [WIDTH-1:0] v);
      return (v != ZERO) && ((v & (v - ONE)) == ZERO);
   endfunction

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_wrap;
   logic             r_err;

   logic [WIDTH-1:0] w_bin_next;
   logic [WIDTH-1:0] w_gray_next;
   logic             w_wrap_next;
   logic             w_count_step;
   logic             w_step_err;

   // Next-state selection: load beats count, count beats hold.
   always_comb begin
      w_bin_next   = r_bin;
      w_wrap_next  = 1'b0;
      w_count_step = 1'b0;
      if (load_in) begin
         w_bin_next = bin_in;
      end else if (en_in) begin
         w_count_step = 1'b1;
         if (up_in) begin
            w_bin_next  = r_bin + ONE;
            w_wrap_next = (r_bin == ALL_ONES);
         end else begin
            w_bin_next  = r_bin - ONE;
            w_wrap_next = (r_bin == ZERO);
         end
      end
      w_gray_next = bin2gray(w_bin_next);
      w_step_err  = w_count_step && !is_single_bit(w_gray_next ^ r_gray);
   end

   // Gray is registered from the next binary value so the output is glitch-free.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_bin  <= RST_BIN;
         r_gray <= bin2gray(RST_BIN);
         r_wrap <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
         r_wrap <= w_wrap_next;
         if (w_step_err) begin
            r_err <= 1'b1;
         end else if (clr_err_in) begin
            r_err <= 1'b0;
         end
      end
   end

   assign bin_out      = r_bin;
   assign gray_out     = r_gray;
   assign wrap_out     = r_wrap;
   assign step_err_out = r_err;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Self-checking bench for bin_to_gray_counter (WIDTH=3): directed sequences plus
// randomized load/enable/direction traffic against an arithmetic model.
module tb_bin_to_gray_counter;

   localparam int W   = 3;
   localparam int MOD = 1 << W;

   logic         clk;
   logic         rst_n;
   logic         load;
   logic [W-1:0] bin_in;
   logic         en;
   logic         up;
   logic         clr;
   logic [W-1:0] bin_out;
   logic [W-1:0] gray_out;
   logic         wrap_out;
   logic         step_err_out;

   int errors = 0;
   int checks = 0;
   logic chk_on = 1'b1;

   bin_to_gray_counter #(.WIDTH(W), .RESET_VAL(0)) dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .load_in      (load),
      .bin_in       (bin_in),
      .en_in        (en),
      .up_in        (up),
      .clr_err_in   (clr),
      .bin_out      (bin_out),
      .gray_out     (gray_out),
      .wrap_out     (wrap_out),
      .step_err_out (step_err_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gray2bin(input logic [W-1:0] g);
      logic [W-1:0] b;
      b[W-1] = g[W-1];
      for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return int'(b);
   endfunction

   function automatic int popcount(input logic [W-1:0] v);
      int n = 0;
      for (int i = 0; i < W; i++) n += int'(v[i]);
      return n;
   endfunction

   // Reference model: plain modular arithmetic on an integer count
   int   m_bin;
   logic m_wrap;
   logic m_step;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_bin  <= 0;
         m_wrap <= 1'b0;
         m_step <= 1'b0;
      end else if (load) begin
         m_bin  <= int'(bin_in);
         m_wrap <= 1'b0;
         m_step <= 1'b0;
      end else if (en) begin
         m_step <= 1'b1;
         if (up) begin
            m_bin  <= (m_bin + 1) % MOD;
            m_wrap <= (m_bin == MOD - 1);
         end else begin
            m_bin  <= (m_bin + MOD - 1) % MOD;
            m_wrap <= (m_bin == 0);
         end
      end else begin
         m_wrap <= 1'b0;
         m_step <= 1'b0;
      end
   end

   // Per-cycle comparison against the model
   logic [W-1:0] prev_gray = '0;
   always @(posedge clk) begin
      #2;
      if (chk_on) begin
         chk("bin", int'(bin_out), m_bin);
         chk("gray", int'(gray_out), m_bin ^ (m_bin >> 1));
         chk("decode", gray2bin(gray_out), int'(bin_out));
         chk("wrap", int'(wrap_out), int'(m_wrap));
         chk("step_err", int'(step_err_out), 0);
         if (m_step && rst_n) chk("gray_1bit", popcount(gray_out ^ prev_gray), 1);
      end
      prev_gray = gray_out;
   end

   task automatic step(input logic l, input int b, input logic e, input logic u, input logic c);
      @(negedge clk);
      load   = l;
      bin_in = W'(b);
      en     = e;
      up     = u;
      clr    = c;
      @(posedge clk);
      #3;
   endtask

   task automatic expect_out(input string name, input int b, input int g, input int w);
      chk({name, "_bin"}, int'(bin_out), b);
      chk({name, "_gray"}, int'(gray_out), g);
      chk({name, "_wrap"}, int'(wrap_out), w);
   endtask

   int up_bin  [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
   int up_gray [9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
   int dn_bin  [3] = '{7, 6, 5};
   int dn_gray [3] = '{4, 5, 7};

   initial begin
      rst_n = 1'b0; load = 1'b0; bin_in = '0; en = 1'b0; up = 1'b1; clr = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      expect_out("reset", 0, 0, 0);
      chk("reset_err", int'(step_err_out), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Up count through a full wrap
      for (int i = 0; i < 9; i++) begin
         step(1'b0, 0, 1'b1, 1'b1, 1'b0);
         expect_out("up", up_bin[i], up_gray[i], (i == 7) ? 1 : 0);
      end

      // Down from zero wraps to all-ones
      step(1'b1, 0, 1'b0, 1'b0, 1'b0);
      expect_out("load0", 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 0, 1'b1, 1'b0, 1'b0);
         expect_out("down", dn_bin[i], dn_gray[i], (i == 0) ? 1 : 0);
      end

      // Load has priority over enable
      step(1'b1, 5, 1'b1, 1'b1, 1'b0);
      expect_out("load_pri", 5, 7, 0);
      step(1'b0, 0, 1'b1, 1'b1, 1'b0);
      expect_out("after_load", 6, 5, 0);

      // Loading the current value changes nothing
      step(1'b1, 6, 1'b0, 1'b0, 1'b0);
      expect_out("reload", 6, 5, 0);

      // Asynchronous reset mid-count
      step(1'b1, 3, 1'b0, 1'b1, 1'b0);
      step(1'b0, 0, 1'b1, 1'b1, 1'b0);
      expect_out("pre_rst", 4, 6, 0);
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 0, 0, 0);
      chk("async_rst_err", int'(step_err_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      up = 1'b1;
      @(posedge clk);
      #3;
      expect_out("post_rst", 1, 1, 0);

      // Corrupt the Gray register to provoke the step checker
      step(1'b1, 1, 1'b0, 1'b1, 1'b0);
      expect_out("pre_inj", 1, 1, 0);
      chk_on = 1'b0;
      @(negedge clk);
      force dut.r_gray = 3'b000;
      load = 1'b0; en = 1'b1; up = 1'b1; clr = 1'b0;
      @(posedge clk);
      #3;
      chk("inj_bin", int'(bin_out), 2);
      chk("inj_err_set", int'(step_err_out), 1);
      @(negedge clk);
      release dut.r_gray;
      en = 1'b0;
      @(posedge clk);
      #3;
      chk("inj_err_sticky", int'(step_err_out), 1);
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      chk("inj_err_clr", int'(step_err_out), 0);
      step(1'b1, 2, 1'b0, 1'b1, 1'b0);
      expect_out("resync", 2, 3, 0);
      chk_on = 1'b1;

      // Randomized traffic
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 9) == 0), int'($urandom_range(0, MOD - 1)),
              ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0));
      end
      step(1'b0, 0, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
